// File: rtl/stage_mem_wb.sv
// Pipeline back end: EX/MEM register, word-addressed data memory, MEM/WB register and write-back mux.
// Optional trap on misaligned loads/stores is enabled by defining MEM_MISALIGN_TRAP_EN.
module stage_mem_wb #(
  parameter int DMEM_DEPTH = 32,
  parameter int DMEM_AW    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  input  logic [31:0] outAlu,
  input  logic        zeroAlu,
  input  logic [31:0] dataRt,
  input  logic [4:0]  inWriteReg,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memToReg,
  input  logic        inRegWrite,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] writeData,
  output logic [4:0]  writeReg,
  output logic        regWrite,
  output logic        zeroMem,
  output logic        misalign
);

  logic        valid_m;
  logic [31:0] alu_m;
  logic        zero_m;
  logic [31:0] rt_m;
  logic [4:0]  reg_m;
  logic        mem_read_m;
  logic        mem_write_m;
  logic        mem_to_reg_m;
  logic        reg_write_m;

  logic        valid_w;
  logic [31:0] data_w;
  logic [4:0]  reg_w;
  logic        reg_write_w;

  logic [31:0] dmem [DMEM_DEPTH];

  logic [DMEM_AW-1:0] addr_m;
  logic [31:0]        rdata_m;
  logic [31:0]        result_m;
  logic               mis_m;
  logic               load_block;
  logic               store_en;

  // Byte address to word address; upper bits drop out so accesses wrap around the memory.
  assign addr_m   = alu_m[DMEM_AW+1:2];
  assign rdata_m  = dmem[addr_m];
  assign result_m = mem_to_reg_m ? rdata_m : alu_m;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;

  assign mis_m      = valid_m & (mem_read_m | mem_write_m) & (alu_m[1:0] != 2'b00);
  assign load_block = mis_m & mem_read_m;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (mis_m && !stall) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign = misalign_q;
`else
  logic unused_mem_read;

  assign unused_mem_read = mem_read_m;
  assign mis_m           = 1'b0;
  assign load_block      = 1'b0;
  assign misalign        = 1'b0;
`endif

  assign store_en = valid_m & mem_write_m & ~stall & ~mis_m;

  // A flush always inserts a bubble, even under stall, so a killed store can never commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_m      <= 1'b0;
      alu_m        <= '0;
      zero_m       <= 1'b0;
      rt_m         <= '0;
      reg_m        <= '0;
      mem_read_m   <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      reg_write_m  <= 1'b0;
    end else if (flush) begin
      valid_m      <= 1'b0;
      alu_m        <= outAlu;
      zero_m       <= zeroAlu;
      rt_m         <= dataRt;
      reg_m        <= inWriteReg;
      mem_read_m   <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      reg_write_m  <= 1'b0;
    end else if (!stall) begin
      valid_m      <= inValid;
      alu_m        <= outAlu;
      zero_m       <= zeroAlu;
      rt_m         <= dataRt;
      reg_m        <= inWriteReg;
      mem_read_m   <= memRead;
      mem_write_m  <= memWrite;
      mem_to_reg_m <= memToReg;
      reg_write_m  <= inRegWrite;
    end
  end

  // Memory write shares this block so a store whose edge meets reset assertion is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_w     <= 1'b0;
      data_w      <= '0;
      reg_w       <= '0;
      reg_write_w <= 1'b0;
    end else if (!stall) begin
      valid_w     <= valid_m;
      data_w      <= result_m;
      reg_w       <= reg_m;
      reg_write_w <= reg_write_m & ~load_block;
      if (store_en) begin
        dmem[addr_m] <= rt_m;
      end
    end
  end

  assign writeData = data_w;
  assign writeReg  = reg_w;
  assign regWrite  = valid_w & reg_write_w & (reg_w != 5'd0);
  assign zeroMem   = zero_m;

endmodule

// File: tb/tb_stage_mem_wb.sv
// Scoreboard bench for stage_mem_wb: directed scenarios plus randomized traffic checked
// against a program-order model of the data memory and register write-back stream.
`timescale 1ns/1ps
module tb_stage_mem_wb;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] out_alu;
  logic        zero_alu;
  logic [31:0] data_rt;
  logic [4:0]  in_write_reg;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        in_reg_write;
  logic        stall;
  logic        flush;
  logic [31:0] write_data;
  logic [4:0]  write_reg;
  logic        reg_write;
  logic        zero_mem;
  logic        misalign;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  wb_t         exp_q[$];
  logic [31:0] mem_model [DEPTH];
  logic        exp_misalign = 1'b0;
  int          errors = 0;
  int          checks = 0;
  bit          adv;

  stage_mem_wb #(.DMEM_DEPTH(32), .DMEM_AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .inValid    (in_valid),
    .outAlu     (out_alu),
    .zeroAlu    (zero_alu),
    .dataRt     (data_rt),
    .inWriteReg (in_write_reg),
    .memRead    (mem_read),
    .memWrite   (mem_write),
    .memToReg   (mem_to_reg),
    .inRegWrite (in_reg_write),
    .stall      (stall),
    .flush      (flush),
    .writeData  (write_data),
    .writeReg   (write_reg),
    .regWrite   (reg_write),
    .zeroMem    (zero_mem),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Program-order model: stores land immediately, loads see every earlier store.
  task automatic model_issue(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                             input bit ld, input bit st, input bit m2r, input bit rw);
    int  w;
    bit  mis;
    wb_t e;
    w   = int'((alu >> 2) % 32'(DEPTH));
    mis = (ld || st) && (alu[1:0] != 2'b00);
`ifdef MEM_MISALIGN_TRAP_EN
    if (mis) exp_misalign = 1'b1;
`else
    mis = 1'b0;
`endif
    if (st && !mis) mem_model[w] = rt;
    if (rw && rd != 5'd0 && !(ld && mis)) begin
      e.data = m2r ? mem_model[w] : alu;
      e.rd   = rd;
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input bit valid, input logic [31:0] alu, input bit zero,
                                input logic [31:0] rt, input logic [4:0] rd, input bit ld,
                                input bit st, input bit m2r, input bit rw, input bit stl,
                                input bit fl, input bit modeled);
    in_valid     = valid;
    out_alu      = alu;
    zero_alu     = zero;
    data_rt      = rt;
    in_write_reg = rd;
    mem_read     = ld;
    mem_write    = st;
    mem_to_reg   = m2r;
    in_reg_write = rw;
    stall        = stl;
    flush        = fl;
    if (modeled && valid && !stl && !fl) model_issue(alu, rt, rd, ld, st, m2r, rw);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 32'h0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic alu_op(input logic [31:0] alu, input bit zero, input logic [4:0] rd);
    apply_stimulus(1, alu, zero, 32'h0, rd, 0, 0, 0, 1, 0, 0, 1);
  endtask

  task automatic store_op(input logic [31:0] addr, input logic [31:0] data);
    apply_stimulus(1, addr, 0, data, 5'd0, 0, 1, 0, 0, 0, 0, 1);
  endtask

  task automatic load_op(input logic [31:0] addr, input logic [4:0] rd);
    apply_stimulus(1, addr, 0, 32'h0, rd, 1, 0, 1, 1, 0, 0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_output({tag, "_write_data"}, write_data, 32'h0);
    check_output({tag, "_write_reg"}, 32'(write_reg), 32'h0);
    check_output({tag, "_reg_write"}, 32'(reg_write), 32'h0);
    check_output({tag, "_zero_mem"}, 32'(zero_mem), 32'h0);
    check_output({tag, "_misalign"}, 32'(misalign), 32'h0);
  endtask

  // Monitor: every WB advance that asserts regWrite consumes the next expected write.
  initial begin
    wb_t e;
    forever begin
      @(posedge clk);
      adv = !stall && !reset;
      @(negedge clk);
      if (adv && reg_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got reg %0d data 0x%08h, want no write", write_reg, write_data);
        end else begin
          e = exp_q.pop_front();
          check_output("wb_data", write_data, e.data);
          check_output("wb_reg", 32'(write_reg), 32'(e.rd));
        end
      end
    end
  end

  initial begin
    bit          stl, fl, v, z, mis_pick;
    int          kind;
    logic [31:0] addr;
    logic [4:0]  rd;

    in_valid = 0; out_alu = 0; zero_alu = 0; data_rt = 0; in_write_reg = 0;
    mem_read = 0; mem_write = 0; mem_to_reg = 0; in_reg_write = 0; stall = 0; flush = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2 check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] initialising data memory");
    for (int i = 0; i < DEPTH; i++) store_op(32'(i * 4), $urandom);
    idle(3);

    $display("[TB] store then load");
    store_op(32'h08, 32'hDEADBEEF);
    load_op(32'h08, 5'd5);
    idle(1);
    check_output("sl_write_data", write_data, 32'hDEADBEEF);
    check_output("sl_write_reg", 32'(write_reg), 32'd5);
    check_output("sl_reg_write", 32'(reg_write), 32'd1);
    idle(2);

    $display("[TB] alu pass-through, zero flag and stall freeze");
    alu_op(32'h7, 0, 5'd3);
    check_output("zero_mem_clear", 32'(zero_mem), 32'd0);
    alu_op(32'h0, 1, 5'd6);
    check_output("alu_write_data", write_data, 32'h7);
    check_output("alu_write_reg", 32'(write_reg), 32'd3);
    check_output("alu_reg_write", 32'(reg_write), 32'd1);
    check_output("zero_mem_set", 32'(zero_mem), 32'd1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 32'h18, 0, 32'h11111111, 5'd0, 0, 1, 0, 0, 1, 0, 1);
      check_output("stall_write_data", write_data, 32'h7);
      check_output("stall_write_reg", 32'(write_reg), 32'd3);
      check_output("stall_reg_write", 32'(reg_write), 32'd1);
      check_output("stall_zero_mem", 32'(zero_mem), 32'd1);
    end
    idle(3);

    $display("[TB] r0 guard");
    alu_op(32'h55, 0, 5'd0);
    idle(1);
    check_output("r0_write_data", write_data, 32'h55);
    check_output("r0_reg_write", 32'(reg_write), 32'd0);
    idle(2);

    $display("[TB] flush together with stall on a store");
    apply_stimulus(1, 32'h10, 0, 32'h12345678, 5'd0, 0, 1, 0, 0, 1, 1, 1);
    idle(2);
    check_output("flush_reg_write", 32'(reg_write), 32'd0);
    load_op(32'h10, 5'd9);
    idle(3);

    $display("[TB] reset between store capture and its write edge");
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    alu_op(32'h1234, 0, 5'd2);
    apply_stimulus(1, 32'h1C, 1, 32'hCAFEF00D, 5'd0, 0, 1, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 check_outputs_zero("midreset");
    in_valid = 0; mem_write = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_misalign = 1'b0;
    exp_q.delete();
    load_op(32'h1C, 5'd4);
    idle(3);

    $display("[TB] misaligned store and loads");
    store_op(32'h0A, 32'hA5A55A5A);
    idle(1);
    check_output("misalign_flag", 32'(misalign), 32'(exp_misalign));
    load_op(32'h08, 5'd7);
    load_op(32'h0A, 5'd8);
    idle(3);
    check_output("misalign_sticky", 32'(misalign), 32'(exp_misalign));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      stl      = ($urandom_range(0, 4) == 0);
      fl       = !stl && ($urandom_range(0, 9) == 0);
      v        = ($urandom_range(0, 7) != 0);
      z        = ($urandom_range(0, 1) == 1);
      kind     = int'($urandom_range(0, 2));
      mis_pick = ($urandom_range(0, 15) == 0);
      addr     = 32'($urandom_range(0, 63)) << 2;
      if (mis_pick) addr[1:0] = 2'($urandom_range(1, 3));
      rd       = 5'($urandom_range(0, 31));
      case (kind)
        0:       apply_stimulus(v, $urandom, z, $urandom, rd, 0, 0, 0, 1, stl, fl, 1);
        1:       apply_stimulus(v, addr, z, $urandom, rd, 1, 0, 1, 1, stl, fl, 1);
        default: apply_stimulus(v, addr, z, $urandom, rd, 0, 1, 0, 0, stl, fl, 1);
      endcase
    end
    idle(4);
    check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check_output("final_misalign", 32'(misalign), 32'(exp_misalign));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
